// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and one APB responder (slave).
interface apb_slave_mem_if #(
    parameter int WIDTH  = 32,
    parameter int SLAVES = 4
);
    logic [SLAVES-1:0] Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [WIDTH-1:0]  Paddr;
    logic [WIDTH-1:0]  Pwdata;
    logic [WIDTH-1:0]  Prdata;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB responder backed by a word-addressed register memory; checks the bridge's
// setup/access sequencing and keeps saturating traffic and error counters.
module apb_slave_mem #(
    parameter int               WIDTH     = 32,
    parameter int               SLAVES    = 4,
    parameter int               SLV_ID    = 0,
    parameter int               DEPTH     = 16,
    parameter logic [WIDTH-1:0] BASE_ADDR = 'h8000_0000
) (
    input  logic                 clock,
    input  logic                 Preset,
    apb_slave_mem_if.slave       apb,
    output logic [15:0]          wr_count,
    output logic [15:0]          rd_count,
    output logic [7:0]           err_count,
    output logic                 prot_err,
    output logic                 oor_err
);
    localparam int               IDX_W = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] SPAN  = WIDTH'(4 * DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  addr_reg;
    logic              write_reg;
    logic [WIDTH-1:0]  wdata_reg;
    logic [WIDTH-1:0]  prdata_reg;
    logic [15:0]       wr_count_reg;
    logic [15:0]       rd_count_reg;
    logic [7:0]        err_count_reg;
    logic              prot_err_reg;
    logic              oor_err_reg;

    logic              sel;
    logic [WIDTH-1:0]  offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              phase_match;
    logic              setup_hit;
    logic              xfer_done;
    logic              violation;
    logic [WIDTH-1:0]  mem_words [DEPTH];

    // Reducing the whole select vector keeps only our bit relevant without slicing.
    assign sel         = |(apb.Pselx & (SLAVES'(1) << SLV_ID));
    assign offset      = apb.Paddr - BASE_ADDR;
    assign in_range    = offset < SPAN;
    assign idx         = offset[IDX_W+1:2];
    assign phase_match = (apb.Paddr == addr_reg) && (apb.Pwrite == write_reg)
                         && (apb.Pwdata == wdata_reg);

    always_comb begin
        state_next = state_reg;
        setup_hit  = 1'b0;
        xfer_done  = 1'b0;
        violation  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel) begin
                    if (apb.Penable) begin
                        violation = 1'b1;
                    end else begin
                        setup_hit  = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A second setup-looking cycle here is an error, never a fresh setup.
                state_next = IDLE;
                if (sel && apb.Penable && phase_match) begin
                    xfer_done = 1'b1;
                end else begin
                    violation = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Preset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (setup_hit) begin
                addr_reg  <= apb.Paddr;
                write_reg <= apb.Pwrite;
                wdata_reg <= apb.Pwdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;
            always_ff @(posedge clock) begin
                if (Preset) begin
                    word_reg <= '0;
                end else if (xfer_done && write_reg && in_range && (idx == IDX_W'(gi))) begin
                    word_reg <= apb.Pwdata;
                end
            end
            assign mem_words[gi] = word_reg;
        end
    endgenerate

    // Read data is fetched at the setup edge so it is stable across the access cycle.
    always_ff @(posedge clock) begin
        if (Preset) begin
            prdata_reg <= '0;
        end else if (setup_hit && !apb.Pwrite) begin
            prdata_reg <= in_range ? mem_words[idx] : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (Preset) begin
            wr_count_reg  <= '0;
            rd_count_reg  <= '0;
            err_count_reg <= '0;
            prot_err_reg  <= 1'b0;
            oor_err_reg   <= 1'b0;
        end else begin
            if (xfer_done && in_range && write_reg && (wr_count_reg != '1)) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
            if (xfer_done && in_range && !write_reg && (rd_count_reg != '1)) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
            if (xfer_done && !in_range) begin
                oor_err_reg <= 1'b1;
            end
            if (violation) begin
                prot_err_reg <= 1'b1;
                if (err_count_reg != '1) begin
                    err_count_reg <= err_count_reg + 8'd1;
                end
            end
        end
    end

    assign apb.Prdata = prdata_reg;
    assign wr_count   = wr_count_reg;
    assign rd_count   = rd_count_reg;
    assign err_count  = err_count_reg;
    assign prot_err   = prot_err_reg;
    assign oor_err    = oor_err_reg;
endmodule
